// File: rtl/lcd_pixel_scheduler.sv
// Pixel source sequencer between the frame-buffer read FIFO and the RGB LCD timing driver.
// Optional colour-bar generator is enabled by defining LCD_SCHED_COLORBAR_EN.
module lcd_pixel_scheduler #(
    parameter int unsigned LOAD_CYC = 16,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned FILL_THR = 256,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic             lcd_pclk,
    input  logic             rst_n,
    input  logic             frame_en,
    input  logic             out_vsync,
    input  logic             data_req,
    input  logic [15:0]      fifo_rdata,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_rd_count,
`ifdef LCD_SCHED_COLORBAR_EN
    input  logic             pattern_sel,
`endif
    output logic             fifo_rd_en,
    output logic             rd_load,
    output logic [15:0]      pixel_data,
    output logic             underflow,
    output logic [7:0]       uf_frames,
    output logic             state_run
);

    localparam int unsigned LdW    = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam logic [LdW-1:0]   LdLast  = LdW'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] FillThr = CNT_W'(FILL_THR);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFill,
        StRun,
        StDrain
    } state_e;

    state_e         state_q;
    logic [LdW-1:0] ld_cnt_q;
    logic           rd_load_q;
    logic           underflow_q;
    logic [7:0]     uf_frames_q;
    logic           vsync_q;
    logic           fs_q;
    logic           src_sel_q;
    logic           start_ok;
    logic           uf_hit;

`ifdef LCD_SCHED_COLORBAR_EN
    assign start_ok = frame_en & ~pattern_sel;
`else
    assign start_ok = frame_en;
`endif

    assign uf_hit     = (state_q == StRun) & data_req & fifo_empty;
    assign fifo_rd_en = (state_q == StRun) & data_req & ~fifo_empty;
    assign rd_load    = rd_load_q;
    assign underflow  = underflow_q;
    assign uf_frames  = uf_frames_q;
    assign state_run  = (state_q == StRun);

    // vsync_q resets high so a vsync level already present at reset release is not a frame start.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b1;
            fs_q      <= 1'b0;
            src_sel_q <= 1'b0;
        end else begin
            vsync_q   <= out_vsync;
            fs_q      <= out_vsync & ~vsync_q;
            src_sel_q <= fifo_rd_en;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ld_cnt_q    <= '0;
            rd_load_q   <= 1'b0;
            underflow_q <= 1'b0;
            uf_frames_q <= 8'd0;
        end else begin
            // Counted even when fs lands in the same cycle: that frame still saw the underflow.
            if (uf_hit) begin
                underflow_q <= 1'b1;
                if (uf_frames_q != 8'hFF) begin
                    uf_frames_q <= uf_frames_q + 8'd1;
                end
            end
            if (fs_q) begin
                ld_cnt_q <= '0;
                if (start_ok) begin
                    state_q   <= StLoad;
                    rd_load_q <= 1'b1;
                end else begin
                    state_q   <= StIdle;
                    rd_load_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    StLoad: begin
                        if (ld_cnt_q == LdLast) begin
                            state_q   <= StFill;
                            rd_load_q <= 1'b0;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + LdW'(1);
                        end
                    end
                    StFill: begin
                        if (fifo_rd_count >= FillThr) begin
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (uf_hit) begin
                            state_q <= StDrain;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef LCD_SCHED_COLORBAR_EN
    logic        pat_q;
    logic        req_q;
    logic        bar_vld_q;
    logic [10:0] x_q;
    logic [10:0] x_idx;
    logic [15:0] bar_q;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] c;
        case (bar)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // A new request burst (line) restarts the bar sequence at pixel 0.
    assign x_idx = (data_req && !req_q) ? 11'd0 : x_q;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= 1'b0;
            req_q     <= 1'b0;
            bar_vld_q <= 1'b0;
            x_q       <= 11'd0;
            bar_q     <= 16'h0000;
        end else begin
            req_q     <= data_req;
            bar_vld_q <= data_req;
            if (data_req) begin
                bar_q <= bar_color(x_idx[8:6]);
            end
            if (fs_q) begin
                pat_q <= pattern_sel;
                x_q   <= 11'd0;
            end else if (data_req) begin
                x_q <= x_idx + 11'd1;
            end
        end
    end

    always_comb begin
        pixel_data = BG_COLOR;
        if (pat_q) begin
            if (bar_vld_q) begin
                pixel_data = bar_q;
            end
        end else if (src_sel_q) begin
            pixel_data = fifo_rdata;
        end
    end
`else
    assign pixel_data = src_sel_q ? fifo_rdata : BG_COLOR;
`endif

endmodule

// File: tb/tb_lcd_pixel_scheduler.sv
// Frame-level bench: drives LCD timing and a FIFO model, predicts pixels from frame rules.
module tb_lcd_pixel_scheduler;
    localparam int unsigned LOAD_CYC = 16;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned FILL_THR = 256;
    localparam logic [15:0] BG       = 16'h0000;
    localparam int VS_CYC    = 101;
    localparam int VBP       = 30;
    localparam int HBLANK    = 20;
    localparam int HPIX      = 480;
    localparam int LINE_CYC  = HBLANK + HPIX;
    localparam int NLINES    = 6;
    localparam int VFP       = 10;
    localparam int FRAME_CYC = VS_CYC + VBP + NLINES * LINE_CYC + VFP;
    localparam int NO_UF     = 1 << 30;
    localparam int NWORDS    = 32768;

    logic             lcd_pclk = 1'b0;
    logic             rst_n;
    logic             frame_en;
    logic             out_vsync;
    logic             data_req;
    logic [15:0]      fifo_rdata;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_rd_count;
`ifdef LCD_SCHED_COLORBAR_EN
    logic             pattern_sel;
`endif
    logic             fifo_rd_en;
    logic             rd_load;
    logic [15:0]      pixel_data;
    logic             underflow;
    logic [7:0]       uf_frames;
    logic             state_run;

    int checks = 0;
    int errors = 0;
    logic [15:0] words [NWORDS];
    int rd_ptr = 0;
    bit m_uf   = 1'b0;
    int m_ufc  = 0;

    lcd_pixel_scheduler #(
        .LOAD_CYC(LOAD_CYC),
        .CNT_W   (CNT_W),
        .FILL_THR(FILL_THR),
        .BG_COLOR(BG)
    ) dut (
        .lcd_pclk     (lcd_pclk),
        .rst_n        (rst_n),
        .frame_en     (frame_en),
        .out_vsync    (out_vsync),
        .data_req     (data_req),
        .fifo_rdata   (fifo_rdata),
        .fifo_empty   (fifo_empty),
        .fifo_rd_count(fifo_rd_count),
`ifdef LCD_SCHED_COLORBAR_EN
        .pattern_sel  (pattern_sel),
`endif
        .fifo_rd_en   (fifo_rd_en),
        .rd_load      (rd_load),
        .pixel_data   (pixel_data),
        .underflow    (underflow),
        .uf_frames    (uf_frames),
        .state_run    (state_run)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    function automatic logic [15:0] bar_exp(input int p);
        case (p / 64)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // One whole frame. uf_k: request index where the FIFO runs empty for the rest of the frame.
    task automatic run_frame(input string name, input bit en, input int unsigned cnt,
                             input int uf_k, input int drop_line, input int rst_at, input bit pat);
        bit good, uf_in, prev_req, rd_s;
        int base, line, pix, kcur, prev_k, prev_pix, u;
        int rl_cnt, rl_first, stray, exp_rl, e;
        int rd_line [NLINES];
        logic [15:0] exp;
        good     = en && !pat && (cnt >= FILL_THR) && (rst_at < 0);
        uf_in    = good && (uf_k < NLINES * HPIX);
        base     = rd_ptr;
        rl_cnt   = 0;
        rl_first = -1;
        stray    = 0;
        prev_req = 1'b0;
        prev_k   = 0;
        prev_pix = 0;
        foreach (rd_line[i]) rd_line[i] = 0;
        frame_en      = en;
        fifo_rd_count = CNT_W'(cnt);
        fifo_empty    = 1'b0;
`ifdef LCD_SCHED_COLORBAR_EN
        pattern_sel = pat;
`endif
        for (int t = 0; t < FRAME_CYC; t++) begin
            out_vsync = (t < VS_CYC);
            data_req  = 1'b0;
            line      = -1;
            pix       = -1;
            kcur      = 0;
            if (t >= VS_CYC + VBP) begin
                u    = t - VS_CYC - VBP;
                line = u / LINE_CYC;
                pix  = u % LINE_CYC - HBLANK;
                if (line >= NLINES) line = -1;
                if (line >= 0 && line == drop_line && pix == -HBLANK) frame_en = 1'b0;
                if (line >= 0 && pix >= 0) begin
                    data_req = 1'b1;
                    kcur     = line * HPIX + pix;
                    if (kcur >= uf_k) fifo_empty = 1'b1;
                end
            end
            #5;
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({rd_load, fifo_rd_en, state_run, underflow} !== 4'b0000 || uf_frames !== 8'd0 ||
                    pixel_data !== BG) begin
                    errors++;
                    $display("FAIL %s async_reset: ld/rd/run/uf=%b%b%b%b cnt=%0d px=%h, need 0000 0 %h",
                             name, rd_load, fifo_rd_en, state_run, underflow, uf_frames, pixel_data, BG);
                end
                m_uf  = 1'b0;
                m_ufc = 0;
            end else begin
                #1;
            end
            if (rd_load) begin
                rl_cnt++;
                if (rl_first < 0) rl_first = t;
            end
            if (fifo_rd_en) begin
                if (data_req && line >= 0) rd_line[line]++;
                else stray++;
            end
            if (prev_req) begin
                if (pat) exp = bar_exp(prev_pix);
                else if (good && prev_k < uf_k) exp = words[(base + prev_k) % NWORDS];
                else exp = BG;
                checks++;
                if (pixel_data !== exp) begin
                    errors++;
                    $display("FAIL %s pixel %0d: got %h, need %h", name, prev_k, pixel_data, exp);
                end
            end
            if (line == 0 && pix == 0) begin
                checks++;
                if (state_run !== good) begin
                    errors++;
                    $display("FAIL %s run_at_first_pixel: got %b, need %b", name, state_run, good);
                end
            end
            rd_s = fifo_rd_en;
            @(posedge lcd_pclk);
            #1;
            if (t == rst_at) rst_n = 1'b1;
            if (rd_s) begin
                fifo_rdata = words[rd_ptr % NWORDS];
                rd_ptr++;
            end
            prev_req = data_req;
            prev_k   = kcur;
            prev_pix = pix;
        end
        if (uf_in) begin
            m_uf = 1'b1;
            if (m_ufc < 255) m_ufc++;
        end
        exp_rl = (rst_at >= 0) ? rst_at - 2 : ((en && !pat) ? int'(LOAD_CYC) : 0);
        checks++;
        if (rl_cnt !== exp_rl) begin
            errors++;
            $display("FAIL %s rd_load_width: got %0d, need %0d", name, rl_cnt, exp_rl);
        end
        if (exp_rl > 0) begin
            checks++;
            if (rl_first !== 2) begin
                errors++;
                $display("FAIL %s rd_load_start: got cycle %0d, need 2", name, rl_first);
            end
        end
        for (int l = 0; l < NLINES; l++) begin
            e = uf_k - l * HPIX;
            if (e < 0) e = 0;
            if (e > HPIX) e = HPIX;
            if (!good) e = 0;
            checks++;
            if (rd_line[l] !== e) begin
                errors++;
                $display("FAIL %s reads_line%0d: got %0d, need %0d", name, l, rd_line[l], e);
            end
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL %s stray_reads: got %0d, need 0", name, stray);
        end
        checks++;
        if (underflow !== m_uf || uf_frames !== 8'(m_ufc)) begin
            errors++;
            $display("FAIL %s underflow_state: got %b/%0d, need %b/%0d", name, underflow, uf_frames,
                     m_uf, m_ufc);
        end
        checks++;
        if (state_run !== (good && !uf_in)) begin
            errors++;
            $display("FAIL %s run_at_frame_end: got %b, need %b", name, state_run, good && !uf_in);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        frame_en      = 1'b1;
        out_vsync     = 1'b0;
        data_req      = 1'b1;
        fifo_empty    = 1'b0;
        fifo_rd_count = 10'd300;
        fifo_rdata    = 16'h8001 | 16'($urandom);
`ifdef LCD_SCHED_COLORBAR_EN
        pattern_sel   = 1'b0;
`endif
        repeat (3) @(posedge lcd_pclk);
        #1;
        checks++; if (rd_load !== 1'b0)    begin errors++; $display("FAIL reset rd_load: got %b, need 0", rd_load); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset fifo_rd_en: got %b, need 0", fifo_rd_en); end
        checks++; if (underflow !== 1'b0)  begin errors++; $display("FAIL reset underflow: got %b, need 0", underflow); end
        checks++; if (uf_frames !== 8'd0)  begin errors++; $display("FAIL reset uf_frames: got %0d, need 0", uf_frames); end
        checks++; if (state_run !== 1'b0)  begin errors++; $display("FAIL reset state_run: got %b, need 0", state_run); end
        checks++; if (pixel_data !== BG)   begin errors++; $display("FAIL reset pixel_data: got %h, need %h", pixel_data, BG); end
        rst_n = 1'b1;
        repeat (4) @(posedge lcd_pclk);
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL idle fifo_rd_en: got %b, need 0", fifo_rd_en); end
        checks++; if (pixel_data !== BG)   begin errors++; $display("FAIL idle pixel_data: got %h, need %h", pixel_data, BG); end
        data_req = 1'b0;
    endtask

    task automatic test_normal();
        run_frame("normal_a", 1'b1, $urandom_range(300, 1023), NO_UF, -1, -1, 1'b0);
        run_frame("normal_thr", 1'b1, FILL_THR, NO_UF, -1, -1, 1'b0);
    endtask

    task automatic test_fill_stall();
        run_frame("stall_100", 1'b1, 100, NO_UF, -1, -1, 1'b0);
        run_frame("stall_255", 1'b1, FILL_THR - 1, NO_UF, -1, -1, 1'b0);
        run_frame("after_stall", 1'b1, 300, NO_UF, -1, -1, 1'b0);
    endtask

    task automatic test_underflow();
        run_frame("uf_l5p200", 1'b1, 300, 5 * HPIX + 200, -1, -1, 1'b0);
        run_frame("after_uf", 1'b1, 300, NO_UF, -1, -1, 1'b0);
        run_frame("uf_random", 1'b1, $urandom_range(256, 1023), $urandom_range(1, NLINES * HPIX - 1),
                  -1, -1, 1'b0);
    endtask

    task automatic test_frame_en_drop();
        run_frame("en_drop", 1'b1, 300, NO_UF, 2, -1, 1'b0);
        run_frame("en_off", 1'b0, 300, NO_UF, -1, -1, 1'b0);
        run_frame("en_back", 1'b1, 300, NO_UF, -1, -1, 1'b0);
    endtask

    task automatic test_reset_in_load();
        run_frame("rst_in_load", 1'b1, 300, NO_UF, -1, 6, 1'b0);
        run_frame("after_rst", 1'b1, 300, NO_UF, -1, -1, 1'b0);
    endtask

`ifdef LCD_SCHED_COLORBAR_EN
    task automatic test_colorbar();
        run_frame("colorbar", 1'b1, 300, NO_UF, -1, -1, 1'b1);
        run_frame("after_bar", 1'b1, 300, NO_UF, -1, -1, 1'b0);
    endtask
`endif

    initial begin
        for (int i = 0; i < NWORDS; i++) words[i] = 16'($urandom);
        test_reset();
        test_normal();
        test_fill_stall();
        test_underflow();
        test_frame_en_drop();
        test_reset_in_load();
`ifdef LCD_SCHED_COLORBAR_EN
        test_colorbar();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
